// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory port bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              MemRead;
    logic              MemWrite;
    logic [1:0]        SaveMethod;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output MemRead, MemWrite, SaveMethod, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  MemRead, MemWrite, SaveMethod, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with byte-serial load assembly; MISALIGN_SPLIT_EN enables split misaligned accesses
// Without MISALIGN_SPLIT_EN, misaligned half/word requests complete with resp_err and touch no memory.
module mem_access_unit #(
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    localparam logic [1:0] SM_SB = 2'b00;
    localparam logic [1:0] SM_SH = 2'b01;
    localparam logic [1:0] SM_SW = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
    logic              split_q, split_d;
`endif

    logic              split_w;
    logic              req_misaligned;
    logic              reject_misaligned;
    logic [1:0]        last_idx;
    logic              store_last;
    logic [31:0]       assembled;
    logic [31:0]       extended;
    logic [7:0]        wbyte;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^bus.mem_rdata[31:8];

    assign req_misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                            ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

`ifdef MISALIGN_SPLIT_EN
    assign split_w           = split_q;
    assign reject_misaligned = 1'b0;
`else
    assign split_w           = 1'b0;
    assign reject_misaligned = req_misaligned;
`endif

    always_comb begin
        case (size_q)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // A split store walks bytes until N-1; an aligned store is always a single cycle.
    assign store_last = !split_w || (idx_q == last_idx);

    always_comb begin
        assembled = buf_q;
        assembled[{idx_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
    end

    always_comb begin
        case (size_q)
            2'd0:    extended = uns_q ? {24'b0, assembled[7:0]}
                                      : {{24{assembled[7]}}, assembled[7:0]};
            2'd1:    extended = uns_q ? {16'b0, assembled[15:0]}
                                      : {{16{assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    assign wbyte = wdata_q[{idx_q, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            split_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MISALIGN_SPLIT_EN
            split_q <= split_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MISALIGN_SPLIT_EN
        split_d = split_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    idx_d   = '0;
                    buf_d   = '0;
`ifdef MISALIGN_SPLIT_EN
                    split_d = req_misaligned;
`endif
                    if ((bus.req_size == 2'd3) || reject_misaligned) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = STORE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                buf_d = assembled;
                idx_d = idx_q + 2'd1;
                if (idx_q == last_idx) begin
                    state_d = RESP;
                    rdata_d = extended;
                    err_d   = 1'b0;
                end
            end
            STORE: begin
                idx_d = idx_q + 2'd1;
                if (store_last) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs depend only on registered state so they are glitch-free toward DataMem.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        bus.MemRead    = (state_q == LOAD);
        bus.MemWrite   = (state_q == STORE);
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.SaveMethod = SM_SB;
        if ((state_q == LOAD) || (state_q == STORE)) begin
            bus.mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, idx_q};
        end
        if (state_q == STORE) begin
            if (split_w) begin
                bus.mem_wdata = {24'b0, wbyte};
            end else begin
                bus.mem_wdata = wdata_q;
                case (size_q)
                    2'd0:    bus.SaveMethod = SM_SB;
                    2'd1:    bus.SaveMethod = SM_SH;
                    default: bus.SaveMethod = SM_SW;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a byte-wide DataMem model
module tb_mem_access_unit;
    localparam logic [1:0] SM_SB = 2'b00;
    localparam logic [1:0] SM_SH = 2'b01;
    localparam logic [1:0] SM_SW = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(6)) bus ();
    mem_access_unit #(.ADDR_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [0:63];
    logic       pl_we = 1'b0;
    logic [5:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;

    assign bus.mem_rdata = {24'b0, mem[bus.mem_addr]};

    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        if (bus.MemWrite) begin
            mem[bus.mem_addr] <= bus.mem_wdata[7:0];
            if (bus.SaveMethod != SM_SB) mem[bus.mem_addr + 6'd1] <= bus.mem_wdata[15:8];
            if (bus.SaveMethod == SM_SW) begin
                mem[bus.mem_addr + 6'd2] <= bus.mem_wdata[23:16];
                mem[bus.mem_addr + 6'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    int          lat, nrd, nwr, na;
    logic        got;
    logic [31:0] r_rdata;
    logic        r_err, r_ready;
    logic [5:0]  alog [8];
    logic [1:0]  slog [8];
    logic [31:0] dlog [8];
    logic        seen_resp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [5:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; na = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.MemRead)  nrd++;
            if (bus.MemWrite) nwr++;
            if ((bus.MemRead || bus.MemWrite) && na < 8) begin
                alog[na] = bus.mem_addr; slog[na] = bus.SaveMethod; dlog[na] = bus.mem_wdata;
                na++;
            end
            if (bus.resp_valid) begin
                got = 1'b1; r_rdata = bus.resp_rdata; r_err = bus.resp_err; r_ready = bus.req_ready;
            end
        end
        chk("resp_within_budget", 32'(got), 32'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_MemRead",    32'(bus.MemRead),    32'd0);
        chk("rst_MemWrite",   32'(bus.MemWrite),   32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
        chk("rst_SaveMethod", 32'(bus.SaveMethod), 32'(SM_SB));
        rst = 1'b1;

        preload(6'd0, 8'h01); preload(6'd1, 8'h05); preload(6'd2, 8'h19);
        preload(6'd62, 8'hAA); preload(6'd63, 8'hBB);

        run_req(1'b0, 2'd0, 1'b1, 6'd1, 32'h0);
        chk("lbu1_latency", 32'(lat), 32'd2);
        chk("lbu1_nread",   32'(nrd), 32'd1);
        chk("lbu1_addr",    32'(alog[0]), 32'd1);
        chk("lbu1_rdata",   r_rdata, 32'h0000_0005);
        chk("lbu1_err",     32'(r_err), 32'd0);
        chk("resp_ready_low", 32'(r_ready), 32'd0);

        run_req(1'b1, 2'd2, 1'b0, 6'd4, 32'hDEAD_BEEF);
        chk("sw_latency", 32'(lat), 32'd2);
        chk("sw_nwrite",  32'(nwr), 32'd1);
        chk("sw_nread",   32'(nrd), 32'd0);
        chk("sw_method",  32'(slog[0]), 32'(SM_SW));
        chk("sw_addr",    32'(alog[0]), 32'd4);
        chk("sw_wdata",   dlog[0], 32'hDEAD_BEEF);
        chk("sw_rdata",   r_rdata, 32'd0);
        chk("sw_err",     32'(r_err), 32'd0);
        chk("sw_mem7",    32'(mem[7]), 32'h0000_00DE);

        run_req(1'b0, 2'd2, 1'b0, 6'd4, 32'h0);
        chk("lw4_latency", 32'(lat), 32'd5);
        chk("lw4_nread",   32'(nrd), 32'd4);
        chk("lw4_addr3",   32'(alog[3]), 32'd7);
        chk("lw4_rdata",   r_rdata, 32'hDEAD_BEEF);

        run_req(1'b0, 2'd1, 1'b0, 6'd4, 32'h0);
        chk("lh4_latency", 32'(lat), 32'd3);
        chk("lh4_rdata",   r_rdata, 32'hFFFF_BEEF);

        run_req(1'b0, 2'd0, 1'b1, 6'd7, 32'h0);
        chk("lbu7_rdata", r_rdata, 32'h0000_00DE);

        run_req(1'b0, 2'd0, 1'b0, 6'd7, 32'h0);
        chk("lb7_rdata", r_rdata, 32'hFFFF_FFDE);

        run_req(1'b0, 2'd1, 1'b1, 6'd6, 32'h0);
        chk("lhu6_rdata", r_rdata, 32'h0000_DEAD);

        run_req(1'b0, 2'd1, 1'b0, 6'd0, 32'h0);
        chk("lh0_rdata", r_rdata, 32'h0000_0501);

        run_req(1'b1, 2'd1, 1'b0, 6'd5, 32'h0000_1234);
`ifdef MISALIGN_SPLIT_EN
        chk("sh5_latency", 32'(lat), 32'd3);
        chk("sh5_nwrite",  32'(nwr), 32'd2);
        chk("sh5_addr0",   32'(alog[0]), 32'd5);
        chk("sh5_addr1",   32'(alog[1]), 32'd6);
        chk("sh5_method0", 32'(slog[0]), 32'(SM_SB));
        chk("sh5_data0",   dlog[0], 32'h0000_0034);
        chk("sh5_data1",   dlog[1], 32'h0000_0012);
        chk("sh5_err",     32'(r_err), 32'd0);
        chk("sh5_mem6",    32'(mem[6]), 32'h0000_0012);
`else
        chk("sh5_latency", 32'(lat), 32'd1);
        chk("sh5_nwrite",  32'(nwr), 32'd0);
        chk("sh5_err",     32'(r_err), 32'd1);
        chk("sh5_rdata",   r_rdata, 32'd0);
        chk("sh5_mem5",    32'(mem[5]), 32'h0000_00BE);
`endif

        run_req(1'b0, 2'd2, 1'b0, 6'd62, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        chk("lw62_latency", 32'(lat), 32'd5);
        chk("lw62_addr1",   32'(alog[1]), 32'd63);
        chk("lw62_addr2",   32'(alog[2]), 32'd0);
        chk("lw62_addr3",   32'(alog[3]), 32'd1);
        chk("lw62_rdata",   r_rdata, 32'h0501_BBAA);
`else
        chk("lw62_latency", 32'(lat), 32'd1);
        chk("lw62_nread",   32'(nrd), 32'd0);
        chk("lw62_err",     32'(r_err), 32'd1);
`endif

        run_req(1'b1, 2'd3, 1'b0, 6'd8, 32'h1111_2222);
        chk("sz3_latency", 32'(lat), 32'd1);
        chk("sz3_err",     32'(r_err), 32'd1);
        chk("sz3_rdata",   r_rdata, 32'd0);
        chk("sz3_strobes", 32'(nrd + nwr), 32'd0);

        run_req(1'b0, 2'd0, 1'b1, 6'd2, 32'h0);
        chk("lbu2_rdata", r_rdata, 32'h0000_0019);
        chk("lbu2_err",   32'(r_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("hold_rdata",      bus.resp_rdata, 32'h0000_0019);
        chk("hold_resp_valid", 32'(bus.resp_valid), 32'd0);

        // Abort an LW in its second LOAD cycle.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 6'd4;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_load1_addr", 32'(bus.mem_addr), 32'd4);
        @(negedge clk);
        chk("abort_load2_addr", 32'(bus.mem_addr), 32'd5);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_MemRead",    32'(bus.MemRead),    32'd0);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_mem_addr",   32'(bus.mem_addr),   32'd0);
        chk("abort_resp_rdata", bus.resp_rdata,      32'd0);
        rst = 1'b1;
        seen_resp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen_resp = 1'b1;
        end
        chk("abort_no_resp",   32'(seen_resp), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
